// File: rtl/wb_sram_responder.sv
// Pipelined Wishbone B4 responder in front of a single-port SRAM macro.
// Requests are decoded into SRAM accesses (or bus errors) and answered in
// order with a fixed latency of READ_LATENCY+2 cycles after acceptance.
module wb_sram_responder #(
    parameter int SRAM_ADDR_WIDTH = 9,
    parameter int READ_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_n_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [3:0]                 wb_sel_i,
    input  logic [31:0]                wb_data_i,
    input  logic [27:0]                wb_adr_i,
    output logic                       wb_ack_o,
    output logic                       wb_stall_o,
    output logic                       wb_error_o,
    output logic [31:0]                wb_data_o,
    output logic                       sram_csb_o,
    output logic                       sram_web_o,
    output logic [3:0]                 sram_wmask_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]                sram_din_o,
    input  logic [31:0]                sram_dout_i
);

    // Counter must hold 0..MAX_OUTSTANDING, and MAX_OUTSTANDING is at most 7.
    localparam int CNT_W  = 3;
    // Tag stage k is valid in cycle N+1+k; the last stage lines up with SRAM read data.
    localparam int STAGES = READ_LATENCY + 1;

    logic                       accept;
    logic                       req_err;
    logic                       issue;
    logic                       resp;
    logic                       resp_good_read;

    logic [CNT_W-1:0]           count_reg;
    logic [CNT_W-1:0]           count_next;

    logic [STAGES-1:0]          pipe_valid_reg;
    logic [STAGES-1:0]          pipe_err_reg;
    logic [STAGES-1:0]          pipe_we_reg;
    logic [STAGES-1:0]          pipe_valid_next;
    logic [STAGES-1:0]          pipe_err_next;
    logic [STAGES-1:0]          pipe_we_next;

    logic                       ack_reg;
    logic                       err_reg;
    logic [31:0]                rdata_reg;

    logic                       csb_reg;
    logic                       web_reg;
    logic [3:0]                 wmask_reg;
    logic [SRAM_ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]                din_reg;

    // Stall depends on registered state only, so a master may sample it freely.
    assign wb_stall_o = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;

    // Misaligned addresses and anything above the SRAM window are bus errors.
    assign req_err = (wb_adr_i[1:0] != 2'b00) ||
                     ((wb_adr_i >> (SRAM_ADDR_WIDTH + 2)) != 28'd0);

    // A write with no byte lanes enabled is acknowledged without touching the SRAM.
    assign issue = accept & ~req_err & ~(wb_we_i & (wb_sel_i == 4'b0000));

    assign resp           = pipe_valid_reg[STAGES-1];
    assign resp_good_read = resp & ~pipe_err_reg[STAGES-1] & ~pipe_we_reg[STAGES-1];

    // Tag pipeline shift; dropping cyc invalidates everything in flight.
    assign pipe_valid_next[0] = accept;
    assign pipe_err_next[0]   = req_err;
    assign pipe_we_next[0]    = wb_we_i;
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        assign pipe_valid_next[gi] = wb_cyc_i & pipe_valid_reg[gi-1];
        assign pipe_err_next[gi]   = pipe_err_reg[gi-1];
        assign pipe_we_next[gi]    = pipe_we_reg[gi-1];
    end

    // Outstanding count: accept and response in the same cycle cancel out.
    always_comb begin
        count_next = count_reg;
        if (!wb_cyc_i) begin
            count_next = '0;
        end else if (accept && !resp) begin
            count_next = count_reg + 1'b1;
        end else if (!accept && resp) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Counter and tag pipeline state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            count_reg      <= '0;
            pipe_valid_reg <= '0;
            pipe_err_reg   <= '0;
            pipe_we_reg    <= '0;
        end else begin
            count_reg      <= count_next;
            pipe_valid_reg <= pipe_valid_next;
            pipe_err_reg   <= pipe_err_next;
            pipe_we_reg    <= pipe_we_next;
        end
    end

    // Response pulse and read data capture, aligned with the oldest tag.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ack_reg   <= wb_cyc_i & resp & ~pipe_err_reg[STAGES-1];
            err_reg   <= wb_cyc_i & resp & pipe_err_reg[STAGES-1];
            rdata_reg <= (wb_cyc_i && resp_good_read) ? sram_dout_i : 32'd0;
        end
    end

    // SRAM control is registered; address/data/mask hold between accesses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            csb_reg   <= 1'b1;
            web_reg   <= 1'b1;
            wmask_reg <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
        end else begin
            csb_reg <= ~issue;
            web_reg <= issue ? ~wb_we_i : 1'b1;
            if (issue) begin
                wmask_reg <= wb_sel_i;
                addr_reg  <= wb_adr_i[SRAM_ADDR_WIDTH+1:2];
                din_reg   <= wb_data_i;
            end
        end
    end

    // Responses are suppressed for as long as the master has cyc low.
    assign wb_ack_o   = ack_reg & wb_cyc_i;
    assign wb_error_o = err_reg & wb_cyc_i;
    assign wb_data_o  = wb_cyc_i ? rdata_reg : 32'd0;

    assign sram_csb_o   = csb_reg;
    assign sram_web_o   = web_reg;
    assign sram_wmask_o = wmask_reg;
    assign sram_addr_o  = addr_reg;
    assign sram_din_o   = din_reg;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Bench for wb_sram_responder: two instances (MAX_OUTSTANDING 4 and 2,
// READ_LATENCY 1), each with a behavioural SRAM. A word-array reference model
// predicts responses and SRAM accesses into queues; a monitor thread pops and
// compares them whenever the DUT presents a response or an SRAM access.
`timescale 1ns/1ps
module tb_wb_sram_responder;

    localparam int AW = 9;
    localparam int RL = 1;
    localparam int NI = 2;
    localparam int QD = 64;
    localparam logic [27:0] WIN_BYTES = 28'(4 << AW);

    typedef struct {
        bit          is_err;
        bit          is_rd;
        logic [31:0] data;
        int          acc_cyc;
    } resp_t;

    typedef struct {
        bit          web;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] din;
    } iss_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cyc   [NI];
    logic        stb   [NI];
    logic        we    [NI];
    logic [3:0]  sel   [NI];
    logic [31:0] wdat  [NI];
    logic [27:0] adr   [NI];
    logic        ack   [NI];
    logic        stall [NI];
    logic        err   [NI];
    logic [31:0] rdat  [NI];
    logic        csb   [NI];
    logic        web   [NI];
    logic [3:0]  wmask [NI];
    logic [AW-1:0] saddr [NI];
    logic [31:0] sdin  [NI];

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        bit   [31:0] mem [1 << AW];
        logic [31:0] rd_q;

        wb_sram_responder #(
            .SRAM_ADDR_WIDTH (AW),
            .READ_LATENCY    (RL),
            .MAX_OUTSTANDING ((gi == 0) ? 4 : 2)
        ) dut (
            .wb_clk_i     (clk),
            .wb_rst_n_i   (rst_n),
            .wb_cyc_i     (cyc[gi]),
            .wb_stb_i     (stb[gi]),
            .wb_we_i      (we[gi]),
            .wb_sel_i     (sel[gi]),
            .wb_data_i    (wdat[gi]),
            .wb_adr_i     (adr[gi]),
            .wb_ack_o     (ack[gi]),
            .wb_stall_o   (stall[gi]),
            .wb_error_o   (err[gi]),
            .wb_data_o    (rdat[gi]),
            .sram_csb_o   (csb[gi]),
            .sram_web_o   (web[gi]),
            .sram_wmask_o (wmask[gi]),
            .sram_addr_o  (saddr[gi]),
            .sram_din_o   (sdin[gi]),
            .sram_dout_i  (rd_q)
        );

        // Synchronous SRAM, read data one cycle after the access is presented.
        always @(posedge clk) begin
            if (csb[gi] === 1'b0) begin
                if (web[gi] === 1'b0) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask[gi][b]) mem[saddr[gi]][8*b +: 8] <= sdin[gi][8*b +: 8];
                end else begin
                    rd_q <= mem[saddr[gi]];
                end
            end
        end
    end

    resp_t       rq [NI][QD];
    iss_t        iq [NI][QD];
    int          rh [NI];
    int          rt [NI];
    int          ih [NI];
    int          it [NI];
    bit   [31:0] ref_mem [NI][1 << AW];
    int          stall_cnt [NI];
    int          ack_cnt   [NI];
    int          first_ack [NI];
    int          last_ack  [NI];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %h expected %h (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    // Reference model: word-addressed memory, decoded with plain arithmetic.
    task automatic expect_req(input int idx, input bit w, input logic [27:0] a,
                              input logic [3:0] s, input logic [31:0] d);
        resp_t r;
        iss_t  q;
        bit    bad;
        int    word;
        bad      = (a % 4 != 0) || (a >= WIN_BYTES);
        word     = int'(a / 4);
        r.is_err = bad;
        r.is_rd  = !w && !bad;
        r.data   = 32'd0;
        r.acc_cyc = cyc_cnt;
        if (!bad) begin
            if (!w) begin
                r.data = ref_mem[idx][word];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[idx][word][8*b +: 8] = d[8*b +: 8];
            end
            if (!w || s != 4'd0) begin
                q.web   = !w;
                q.addr  = word;
                q.wmask = s;
                q.din   = d;
                iq[idx][it[idx] % QD] = q;
                it[idx]++;
            end
        end
        rq[idx][rt[idx] % QD] = r;
        rt[idx]++;
        $display("req inst%0d we=%0d adr=%h sel=%h data=%h -> %s", idx, w, a, s, d,
                 bad ? "error" : "ack");
    endtask

    // Present one request and hold it until the DUT takes it.
    task automatic send(input int idx, input bit w, input logic [27:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        int waited = 0;
        cyc[idx] = 1'b1; stb[idx] = 1'b1; we[idx] = w;
        adr[idx] = a; sel[idx] = s; wdat[idx] = d;
        @(negedge clk);
        while (stall[idx] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("stall_release", idx, 32'(stall[idx]), 32'd0);
        if (!stall[idx]) expect_req(idx, w, a, s, d);
        @(posedge clk); #1;
        stb[idx] = 1'b0;
    endtask

    task automatic drain(input int idx);
        int n = 0;
        while ((rh[idx] != rt[idx] || ih[idx] != it[idx]) && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", idx, 32'(rt[idx] - rh[idx] + it[idx] - ih[idx]), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input int idx);
        chk("rst_ack",   idx, 32'(ack[idx]),   32'd0);
        chk("rst_err",   idx, 32'(err[idx]),   32'd0);
        chk("rst_stall", idx, 32'(stall[idx]), 32'd0);
        chk("rst_data",  idx, rdat[idx],       32'd0);
        chk("rst_csb",   idx, 32'(csb[idx]),   32'd1);
        chk("rst_web",   idx, 32'(web[idx]),   32'd1);
        chk("rst_wmask", idx, 32'(wmask[idx]), 32'd0);
        chk("rst_addr",  idx, 32'(saddr[idx]), 32'd0);
        chk("rst_din",   idx, sdin[idx],       32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: time %0t exceeded limit 2000000", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0; sel[i] = 0; wdat[i] = 0; adr[i] = 0;
            rh[i] = 0; rt[i] = 0; ih[i] = 0; it[i] = 0;
            stall_cnt[i] = 0; ack_cnt[i] = 0; first_ack[i] = -1; last_ack[i] = -1;
            for (int w = 0; w < (1 << AW); w++) ref_mem[i][w] = 32'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_reset_outputs(i);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fork
            begin : monitor
                resp_t e;
                iss_t  q;
                bit    rd_ack;
                forever begin
                    @(negedge clk);
                    for (int i = 0; i < NI; i++) begin
                        rd_ack = 1'b0;
                        if (stall[i]) stall_cnt[i]++;
                        if (ack[i] || err[i]) begin
                            chk("ack_err_exclusive", i, 32'(ack[i] & err[i]), 32'd0);
                            if (rh[i] == rt[i]) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_response inst%0d: got ack=%0d err=%0d expected none (t=%0t)",
                                         i, ack[i], err[i], $time);
                            end else begin
                                e = rq[i][rh[i] % QD];
                                rh[i]++;
                                chk("resp_is_error", i, 32'(err[i]), 32'(e.is_err));
                                chk("resp_latency", i, 32'(cyc_cnt - e.acc_cyc), 32'(RL + 2));
                                if (e.is_rd && ack[i]) begin
                                    rd_ack = 1'b1;
                                    chk("read_data", i, rdat[i], e.data);
                                end
                                if (first_ack[i] < 0) first_ack[i] = cyc_cnt;
                                last_ack[i] = cyc_cnt;
                                ack_cnt[i]++;
                                $display("resp inst%0d ack=%0d err=%0d data=%h", i, ack[i], err[i], rdat[i]);
                            end
                        end
                        if (!rd_ack) chk("data_zero", i, rdat[i], 32'd0);
                        if (csb[i] === 1'b0) begin
                            if (ih[i] == it[i]) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_sram_access inst%0d: got csb=0 addr=%h expected csb=1 (t=%0t)",
                                         i, saddr[i], $time);
                            end else begin
                                q = iq[i][ih[i] % QD];
                                ih[i]++;
                                chk("sram_web",   i, 32'(web[i]),   32'(q.web));
                                chk("sram_addr",  i, 32'(saddr[i]), q.addr);
                                chk("sram_wmask", i, 32'(wmask[i]), 32'(q.wmask));
                                chk("sram_din",   i, sdin[i],       q.din);
                            end
                        end else begin
                            chk("sram_web_idle", i, 32'(web[i]), 32'd1);
                        end
                    end
                end
            end
            begin : stimulus
                logic [27:0] a;
                int          r;
                // Single write then read back.
                send(0, 1'b1, 28'h10, 4'hF, 32'hDEADBEEF);
                send(0, 1'b0, 28'h10, 4'hF, 32'h0);
                drain(0);
                // Byte-lane write over a known word.
                send(0, 1'b1, 28'h20, 4'hF, 32'hAABBCCDD);
                send(0, 1'b1, 28'h20, 4'b0100, 32'h11223344);
                send(0, 1'b0, 28'h20, 4'hF, 32'h0);
                drain(0);
                // Back-to-back reads: full rate on inst0, stalled on inst1.
                for (int idx = 0; idx < NI; idx++) begin
                    stall_cnt[idx] = 0; ack_cnt[idx] = 0; first_ack[idx] = -1;
                    for (int k = 0; k < 8; k++) send(idx, 1'b0, 28'(4 * k), 4'hF, $urandom);
                    drain(idx);
                    chk("b2b_ack_count", idx, 32'(ack_cnt[idx]), 32'd8);
                end
                chk("b2b_no_stall", 0, 32'(stall_cnt[0]), 32'd0);
                chk("b2b_consecutive", 0, 32'(last_ack[0] - first_ack[0]), 32'd7);
                chk("b2b_stall_seen", 1, 32'(stall_cnt[1] > 0), 32'd1);
                // Errors interleaved with good requests.
                send(0, 1'b0, 28'h12, 4'hF, 32'h0);
                send(0, 1'b0, 28'h800, 4'hF, 32'h0);
                send(0, 1'b0, 28'h10, 4'hF, 32'h0);
                send(0, 1'b1, 28'h8000000, 4'hF, 32'h12345678);
                send(0, 1'b1, 28'h7FC, 4'hF, 32'hCAFEF00D);
                send(0, 1'b0, 28'h7FC, 4'hF, 32'h0);
                send(0, 1'b0, 28'h7FE, 4'hF, 32'h0);
                send(0, 1'b1, 28'h30, 4'h0, 32'h55555555);
                send(0, 1'b0, 28'h30, 4'hF, 32'h0);
                drain(0);
                // Abort: drop cyc right after three accepted reads.
                send(1, 1'b0, 28'h10, 4'hF, 32'h0);
                send(1, 1'b0, 28'h14, 4'hF, 32'h0);
                send(1, 1'b0, 28'h18, 4'hF, 32'h0);
                cyc[1] = 1'b0;
                rh[1] = rt[1];
                @(posedge clk); #1;
                chk("abort_stall", 1, 32'(stall[1]), 32'd0);
                cyc[1] = 1'b1;
                repeat (4) @(posedge clk); #1;
                send(1, 1'b0, 28'h10, 4'hF, 32'h0);
                send(1, 1'b1, 28'h14, 4'hF, 32'h9ABCDEF0);
                send(1, 1'b0, 28'h14, 4'hF, 32'h0);
                drain(1);
                // Asynchronous reset in the middle of a burst.
                send(0, 1'b0, 28'h10, 4'hF, 32'h0);
                send(0, 1'b0, 28'h14, 4'hF, 32'h0);
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs(0);
                for (int i = 0; i < NI; i++) begin
                    rh[i] = rt[i];
                    ih[i] = it[i];
                end
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                send(0, 1'b0, 28'h7FC, 4'hF, 32'h0);
                drain(0);
                // Randomised traffic against the reference model.
                for (int idx = 0; idx < NI; idx++) begin
                    for (int n = 0; n < 100; n++) begin
                        r = $urandom_range(0, 99);
                        a = 28'(4 * $urandom_range(0, 31));
                        if (r < 8)       a = a + 28'($urandom_range(1, 3));
                        else if (r < 14) a = 28'($urandom_range(2048, 32'h0FFFFFFF));
                        else if (r < 20) a = 28'(4 * $urandom_range(0, 511));
                        send(idx, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
                        if ($urandom_range(0, 3) == 0) begin
                            repeat ($urandom_range(1, 3)) @(posedge clk);
                            #1;
                        end
                    end
                    drain(idx);
                end
            end
        join_any

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_sram_responder.md
Name: wb_sram_responder

Overview:
- Pipelined Wishbone B4 responder (slave) for the 28-bit user-space master bus driven by the host: cyc/stb/we/sel/data/adr[27:0] in; ack/stall/error/data out.
- Decodes each request to a single-port SRAM macro (active-low chip select and write enable, byte write mask), or raises a bus error.
- Returns responses in order with fixed latency, and supports back-to-back requests up to an outstanding limit.

Parameters:
- SRAM_ADDR_WIDTH, 9, word-address width of the SRAM; the window is byte addresses 0 .. 4*2^SRAM_ADDR_WIDTH-1.
- READ_LATENCY, 1, cycles from SRAM control presentation to valid sram_dout_i; legal range 1..3.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests; legal range 1..7.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  request strobe
- wb_we_i  in  1  write enable
- wb_sel_i  in  4  byte select
- wb_data_i  in  32  write data
- wb_adr_i  in  28  byte address
- wb_ack_o  out  1  successful completion
- wb_stall_o  out  1  request not accepted this cycle
- wb_error_o  out  1  erroneous completion
- wb_data_o  out  32  read data
- sram_csb_o  out  1  SRAM chip select, active low
- sram_web_o  out  1  SRAM write enable, active low
- sram_wmask_o  out  4  SRAM byte write mask
- sram_addr_o  out  SRAM_ADDR_WIDTH  SRAM word address
- sram_din_o  out  32  SRAM write data
- sram_dout_i  in  32  SRAM read data

Behaviour:
- Reset values (asynchronous, wb_rst_n_i low):
  - wb_ack_o=0, wb_error_o=0, wb_stall_o=0, wb_data_o=0.
  - sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_din_o=0.
  - Outstanding counter=0; all pipeline tags invalid.
- Accept condition: wb_cyc_i & wb_stb_i & !wb_stall_o, sampled at the rising edge ending cycle N. At most one accept per cycle.
- wb_stall_o = (outstanding == MAX_OUTSTANDING). It is combinational from registered state only and never depends on wb_stb_i.
- Decode at accept: a request is an error when wb_adr_i[1:0] != 0, or when wb_adr_i[27:SRAM_ADDR_WIDTH+2] != 0.
- SRAM issue, in cycle N+1 (registered outputs):
  - Valid request: sram_csb_o=0, sram_web_o=!wb_we_i, sram_addr_o=wb_adr_i[SRAM_ADDR_WIDTH+1:2], sram_din_o=wb_data_i, sram_wmask_o=wb_sel_i.
  - Error request, or write with wb_sel_i==0: sram_csb_o stays 1.
  - Any cycle with no issue: sram_csb_o=1 and sram_web_o=1. Address and data fields hold their last values.
- Response pipeline:
  - Each accept pushes a tag {valid, err, we} into a shift pipeline of READ_LATENCY+1 stages.
  - The response is emitted in cycle N+2+READ_LATENCY as a single-cycle pulse: wb_ack_o=1 for good requests, wb_error_o=1 for error requests.
  - wb_ack_o and wb_error_o are never high together.
  - Error requests traverse the same pipeline so ordering is preserved.
- Read data:
  - For a good read, wb_data_o is registered from sram_dout_i at the edge ending cycle N+1+READ_LATENCY, so it is valid exactly during the ack cycle.
  - wb_data_o=0 during write acks, errors and idle cycles.
- Outstanding counter:
  - +1 on accept, -1 on response, unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never wraps.
- Throughput: full rate (one request per cycle, stall never asserted) requires MAX_OUTSTANDING >= READ_LATENCY+2. A smaller value inserts stall cycles but responses stay correct.
- Abort (wb_cyc_i low):
  - At the next edge, all in-flight tags are invalidated and the counter is cleared.
  - wb_ack_o and wb_error_o are gated by wb_cyc_i and stay 0 while cyc is low.
  - SRAM accesses already presented complete normally: no write is cancelled and no new access is issued.
  - A request accepted in the same cycle cyc falls cannot occur (accept requires cyc).
- stb low with cyc high: no accept; the pipeline continues draining.
- Reset mid-operation: all state returns to reset values immediately; pending responses are lost.

Test Plan:
- Single write then read: write 0xDEADBEEF to 0x0000010 with sel=4'hF, then read 0x0000010. Require ack 3 cycles after each accept (READ_LATENCY=1), wb_data_o=0xDEADBEEF in the read ack cycle, SRAM sees addr=4 and wmask=F.
- Byte write: write 0x11223344 with sel=4'b0100 to 0x0000020, then read. Require sram_wmask_o=4'b0100; read returns only byte 2 changed (0x22 in [23:16]).
- Back-to-back: 8 consecutive reads with MAX_OUTSTANDING=4 and READ_LATENCY=1. Require stall never asserted, 8 acks in 8 consecutive cycles, in order. With MAX_OUTSTANDING=2, require stall asserted while 2 are outstanding and all 8 still acked in order.
- Errors: read 0x0000012 (misaligned) and read 0x0000800 with SRAM_ADDR_WIDTH=9. Require wb_error_o pulses at the same latency as an ack, wb_ack_o=0, sram_csb_o stays 1. Interleaved good/bad requests respond in order.
- Abort: issue 3 reads, drop cyc one cycle later. Require no ack/error appears, stall=0 and counter=0 after the next edge, and a new cycle then behaves normally.
- Reset: assert wb_rst_n_i mid-burst asynchronously. Require all outputs go to reset values before the next clock edge, with sram_csb_o=1.
